boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/loader_pkg.sv | 24 ++
 rtl/boot_loader_if.sv | 16 +
 rtl/word_assembler.sv | 57 +++++
 rtl/boot_loader.sv | 159 +++++++++++++++
 tb/tb_boot_loader.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot loader.
package loader_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } state_t;

    // Width of the LEN byte that carries the word count.
    localparam int LenWidth  = 8;
    // Width of the running XOR checksum.
    localparam int CsumWidth = 8;

    // True in the states that take bytes from the stream.
    function automatic logic accepts_bytes(input state_t s);
        return (s == LEN) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream handshake bundle feeding the loader.
interface boot_loader_if;
    import loader_pkg::*;

    logic                inValid;
    logic [LenWidth-1:0] inData;
    logic                inReady;

    // Producer side: drives the payload, watches ready.
    modport master  (output inValid, inData, input inReady);
    // Consumer side: takes the payload, drives ready.
    modport slave   (input inValid, inData, output inReady);
    // Passive tap: sees every transfer, drives nothing.
    modport monitor (input inValid, inData, inReady);

endinterface

// File: rtl/word_assembler.sv
// Packs accepted stream bytes into little-endian words and pulses
// wordValid_o for one cycle after the fourth byte of each word.
module word_assembler
    import loader_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clear_i,     // drop any partial word
    input  logic             en_i,        // loader is in its data phase
    boot_loader_if.monitor   bs,
    output logic             last_o,      // next accepted byte completes a word
    output logic             wordValid_o,
    output logic [Width-1:0] word_o
);

    logic [1:0]       cnt_q;
    logic [Width-1:0] shift_q;
    logic [Width-1:0] word_q;
    logic             valid_q;
    logic             accept;

    // A byte is only taken while the loader is in its data phase and no
    // restart is pending; a restart on the same edge discards the byte.
    assign accept = bs.inValid && bs.inReady && en_i && !clear_i;

    // Byte counter, shift register, completed word and its strobe.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q   <= 2'd0;
            shift_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else if (clear_i) begin
            cnt_q   <= 2'd0;
            shift_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else if (accept) begin
            // New bytes enter at the top so the first byte ends up in [7:0].
            shift_q <= {bs.inData, shift_q[Width-1:LenWidth]};
            cnt_q   <= cnt_q + 2'd1;
            valid_q <= (cnt_q == 2'd3);
            if (cnt_q == 2'd3) begin
                word_q <= {bs.inData, shift_q[Width-1:LenWidth]};
            end
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign last_o      = (cnt_q == 2'd3);
    assign wordValid_o = valid_q;
    assign word_o      = word_q;

endmodule

// File: rtl/boot_loader.sv
// Boot loader: receives LEN, N little-endian words and an XOR checksum
// over a byte stream, writes the words to instruction memory and releases
// the core only after the checksum matches.
module boot_loader
    import loader_pkg::*;
#(
    parameter int Width = 32,
    parameter int Depth = 32
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                start,
    input  logic                inValid,
    input  logic [LenWidth-1:0] inData,
    output logic                inReady,
    output logic                memWrEn,
    output logic [31:0]         memWrAddr,
    output logic [Width-1:0]    memWrData,
    output logic                coreReset,
    output logic                done,
    output logic                error
);

    // One extra bit so that a count equal to Depth is representable.
    localparam int IdxW = $clog2(Depth) + 1;

    state_t               state_q;
    logic                 rst_sync_q;
    logic                 inReady_q;
    logic                 coreReset_q;
    logic                 done_q;
    logic                 error_q;
    logic [IdxW-1:0]      n_q;
    logic [IdxW-1:0]      word_idx_q;
    logic [CsumWidth-1:0] xor_q;
    logic [31:0]          addr_q;

    logic                 xfer;
    logic                 asm_last;
    logic                 asm_valid;
    logic [Width-1:0]     asm_word;

    assign xfer = inValid && inReady_q;

    // Internal view of the stream so the assembler can tap transfers.
    boot_loader_if bs_if ();
    assign bs_if.inValid = inValid;
    assign bs_if.inData  = inData;
    assign bs_if.inReady = inReady_q;

    word_assembler #(
        .Width(Width)
    ) u_asm (
        .clk         (clk),
        .resetN      (resetN),
        .clear_i     (start),
        .en_i        (state_q == DATA),
        .bs          (bs_if),
        .last_o      (asm_last),
        .wordValid_o (asm_valid),
        .word_o      (asm_word)
    );

    // Loader FSM with its checksum, word index and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            rst_sync_q  <= 1'b0;
            inReady_q   <= 1'b0;
            coreReset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            n_q         <= '0;
            word_idx_q  <= '0;
            xor_q       <= '0;
            addr_q      <= '0;
        end else begin
            // Holds IDLE for one edge after reset release so the first
            // move to LEN happens on the second rising edge.
            rst_sync_q <= 1'b1;
            if (start) begin
                state_q     <= IDLE;
                inReady_q   <= 1'b0;
                coreReset_q <= 1'b1;
                done_q      <= 1'b0;
                error_q     <= 1'b0;
                n_q         <= '0;
                word_idx_q  <= '0;
                xor_q       <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (rst_sync_q) begin
                            state_q   <= LEN;
                            inReady_q <= accepts_bytes(LEN);
                        end
                    end
                    LEN: begin
                        if (xfer) begin
                            if ((inData == '0) || (32'(inData) > 32'(Depth))) begin
                                state_q   <= ERROR;
                                inReady_q <= 1'b0;
                                error_q   <= 1'b1;
                            end else begin
                                state_q <= DATA;
                                n_q     <= IdxW'(inData);
                            end
                        end
                    end
                    DATA: begin
                        if (xfer) begin
                            xor_q <= xor_q ^ inData;
                            if (asm_last) begin
                                // Address latched with the word it belongs to.
                                addr_q     <= 32'({word_idx_q, 2'b00});
                                word_idx_q <= word_idx_q + 1'b1;
                                if (IdxW'(word_idx_q + 1'b1) == n_q) begin
                                    state_q <= CHECK;
                                end
                            end
                        end
                    end
                    CHECK: begin
                        if (xfer) begin
                            inReady_q <= 1'b0;
                            if (inData == xor_q) begin
                                state_q     <= DONE;
                                done_q      <= 1'b1;
                                coreReset_q <= 1'b0;
                            end else begin
                                state_q <= ERROR;
                                error_q <= 1'b1;
                            end
                        end
                    end
                    DONE, ERROR: begin
                        // Wait here until a restart.
                    end
                    default: begin
                        state_q     <= IDLE;
                        inReady_q   <= 1'b0;
                        coreReset_q <= 1'b1;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign inReady   = inReady_q;
    assign memWrEn   = asm_valid;
    assign memWrAddr = addr_q;
    assign memWrData = asm_word;
    assign coreReset = coreReset_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: drives byte streams through the
// handshake interface and checks writes, status and reset behaviour.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        resetN;
    logic        start;
    logic        memWrEn;
    logic [31:0] memWrAddr;
    logic [31:0] memWrData;
    logic        coreReset;
    logic        done;
    logic        error;

    boot_loader_if tb_if ();

    always #5 clk = ~clk;

    boot_loader #(
        .Width(32),
        .Depth(32)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .start     (start),
        .inValid   (tb_if.inValid),
        .inData    (tb_if.inData),
        .inReady   (tb_if.inReady),
        .memWrEn   (memWrEn),
        .memWrAddr (memWrAddr),
        .memWrData (memWrData),
        .coreReset (coreReset),
        .done      (done),
        .error     (error)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int gap      = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    // Record every memory write; memWrEn is high for one whole cycle.
    always @(negedge clk) begin
        if (memWrEn === 1'b1) begin
            wr_addr.push_back(memWrAddr);
            wr_data.push_back(memWrData);
            $display("write addr=%08h data=%08h", memWrAddr, memWrData);
        end
    end

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hxxxxxxxx;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        repeat (gap) @(posedge clk);
        @(negedge clk);
        tb_if.inValid = 1'b1;
        tb_if.inData  = b;
        while (tb_if.inReady !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: inReady never rose for byte %02h", b);
        end
        @(posedge clk);
        #1;
        tb_if.inValid = 1'b0;
        $display("byte %02h", b);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        start  = 1'b0;
        tb_if.inValid = 1'b0;
        tb_if.inData  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (coreReset !== 1'b1) begin n_fail++; $display("FAIL rst_coreReset: got %b expected 1", coreReset); end
        n_checks++; if (tb_if.inReady !== 1'b0) begin n_fail++; $display("FAIL rst_inReady: got %b expected 0", tb_if.inReady); end
        n_checks++; if (memWrEn !== 1'b0) begin n_fail++; $display("FAIL rst_memWrEn: got %b expected 0", memWrEn); end
        n_checks++; if (memWrAddr !== 32'h0) begin n_fail++; $display("FAIL rst_memWrAddr: got %h expected 0", memWrAddr); end
        n_checks++; if (memWrData !== 32'h0) begin n_fail++; $display("FAIL rst_memWrData: got %h expected 0", memWrData); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b expected 0", error); end
        @(negedge clk);
        resetN = 1'b1;
        // Still IDLE after the first edge, in LEN after the second.
        @(posedge clk); #1;
        n_checks++; if (tb_if.inReady !== 1'b0) begin n_fail++; $display("FAIL rel_edge1_inReady: got %b expected 0", tb_if.inReady); end
        @(posedge clk); #1;
        n_checks++; if (tb_if.inReady !== 1'b1) begin n_fail++; $display("FAIL rel_edge2_inReady: got %b expected 1", tb_if.inReady); end
    endtask

    task automatic test_single_word();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h13);
        settle();
        n_checks++; if (wr_addr.size() != 1) begin n_fail++; $display("FAIL one_wr_count: got %0d expected 1", wr_addr.size()); end
        n_checks++; if (q_at(wr_addr, 0) !== 32'h0) begin n_fail++; $display("FAIL one_wr_addr: got %h expected 00000000", q_at(wr_addr, 0)); end
        n_checks++; if (q_at(wr_data, 0) !== 32'h00000013) begin n_fail++; $display("FAIL one_wr_data: got %h expected 00000013", q_at(wr_data, 0)); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL one_done: got %b expected 1", done); end
        n_checks++; if (coreReset !== 1'b0) begin n_fail++; $display("FAIL one_coreReset: got %b expected 0", coreReset); end
        n_checks++; if (tb_if.inReady !== 1'b0) begin n_fail++; $display("FAIL one_inReady: got %b expected 0", tb_if.inReady); end
    endtask

    // XOR of all eight data bytes 93 00 10 00 13 01 20 00 is 0xB1.
    task automatic two_word_stream(input logic [7:0] csum);
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h01); send_byte(8'h20); send_byte(8'h00);
        send_byte(csum);
        settle();
    endtask

    task automatic test_two_words();
        gap = 2;
        two_word_stream(8'hB1);
        gap = 0;
        n_checks++; if (wr_addr.size() != 2) begin n_fail++; $display("FAIL two_wr_count: got %0d expected 2", wr_addr.size()); end
        n_checks++; if (q_at(wr_addr, 0) !== 32'h0) begin n_fail++; $display("FAIL two_wr0_addr: got %h expected 00000000", q_at(wr_addr, 0)); end
        n_checks++; if (q_at(wr_data, 0) !== 32'h00100093) begin n_fail++; $display("FAIL two_wr0_data: got %h expected 00100093", q_at(wr_data, 0)); end
        n_checks++; if (q_at(wr_addr, 1) !== 32'h4) begin n_fail++; $display("FAIL two_wr1_addr: got %h expected 00000004", q_at(wr_addr, 1)); end
        n_checks++; if (q_at(wr_data, 1) !== 32'h00200113) begin n_fail++; $display("FAIL two_wr1_data: got %h expected 00200113", q_at(wr_data, 1)); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL two_done: got %b expected 1", done); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL two_error: got %b expected 0", error); end
    endtask

    task automatic test_bad_checksum();
        two_word_stream(8'hAA);
        n_checks++; if (wr_addr.size() != 2) begin n_fail++; $display("FAIL bad_wr_count: got %0d expected 2", wr_addr.size()); end
        n_checks++; if (q_at(wr_data, 1) !== 32'h00200113) begin n_fail++; $display("FAIL bad_wr1_data: got %h expected 00200113", q_at(wr_data, 1)); end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL bad_error: got %b expected 1", error); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL bad_done: got %b expected 0", done); end
        n_checks++; if (coreReset !== 1'b1) begin n_fail++; $display("FAIL bad_coreReset: got %b expected 1", coreReset); end
        n_checks++; if (tb_if.inReady !== 1'b0) begin n_fail++; $display("FAIL bad_inReady: got %b expected 0", tb_if.inReady); end
    endtask

    task automatic test_len_bounds();
        pulse_start();
        send_byte(8'h00);
        settle();
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL len0_error: got %b expected 1", error); end
        n_checks++; if (tb_if.inReady !== 1'b0) begin n_fail++; $display("FAIL len0_inReady: got %b expected 0", tb_if.inReady); end
        n_checks++; if (wr_addr.size() != 0) begin n_fail++; $display("FAIL len0_wr_count: got %0d expected 0", wr_addr.size()); end
        pulse_start();
        send_byte(8'h21);
        settle();
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL len33_error: got %b expected 1", error); end
        n_checks++; if (coreReset !== 1'b1) begin n_fail++; $display("FAIL len33_coreReset: got %b expected 1", coreReset); end
        n_checks++; if (wr_addr.size() != 0) begin n_fail++; $display("FAIL len33_wr_count: got %0d expected 0", wr_addr.size()); end
        // N equal to Depth is the largest legal count.
        pulse_start();
        send_byte(8'h20);
        settle();
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL len32_error: got %b expected 0", error); end
        n_checks++; if (tb_if.inReady !== 1'b1) begin n_fail++; $display("FAIL len32_inReady: got %b expected 1", tb_if.inReady); end
    endtask

    task automatic test_start_abort();
        pulse_start();
        send_byte(8'h03);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        send_byte(8'hEE); send_byte(8'hFF);
        n_checks++; if (q_at(wr_data, 0) !== 32'hDDCCBBAA) begin n_fail++; $display("FAIL abort_wr0_data: got %h expected ddccbbaa", q_at(wr_data, 0)); end
        // Restart on the same edge as a byte: the byte must be dropped.
        @(negedge clk);
        start = 1'b1;
        tb_if.inValid = 1'b1;
        tb_if.inData  = 8'h77;
        @(posedge clk); #1;
        start = 1'b0;
        tb_if.inValid = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        n_checks++; if (tb_if.inReady !== 1'b0) begin n_fail++; $display("FAIL abort_idle_inReady: got %b expected 0", tb_if.inReady); end
        n_checks++; if (coreReset !== 1'b1) begin n_fail++; $display("FAIL abort_coreReset: got %b expected 1", coreReset); end
        send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h44);
        settle();
        n_checks++; if (wr_addr.size() != 1) begin n_fail++; $display("FAIL abort_wr_count: got %0d expected 1", wr_addr.size()); end
        n_checks++; if (q_at(wr_addr, 0) !== 32'h0) begin n_fail++; $display("FAIL abort_wr_addr: got %h expected 00000000", q_at(wr_addr, 0)); end
        n_checks++; if (q_at(wr_data, 0) !== 32'h44332211) begin n_fail++; $display("FAIL abort_wr_data: got %h expected 44332211", q_at(wr_data, 0)); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL abort_done: got %b expected 1", done); end
    endtask

    task automatic test_reset_in_done();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h5A); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h5A);
        settle();
        n_checks++; if (coreReset !== 1'b0) begin n_fail++; $display("FAIL rd_pre_coreReset: got %b expected 0", coreReset); end
        // Assert reset between edges: outputs must react without a clock.
        @(negedge clk);
        #2;
        resetN = 1'b0;
        #1;
        n_checks++; if (coreReset !== 1'b1) begin n_fail++; $display("FAIL rd_async_coreReset: got %b expected 1", coreReset); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rd_async_done: got %b expected 0", done); end
        n_checks++; if (memWrData !== 32'h0) begin n_fail++; $display("FAIL rd_async_memWrData: got %h expected 0", memWrData); end
        @(negedge clk);
        resetN = 1'b1;
        wr_addr.delete();
        wr_data.delete();
        send_byte(8'h01);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h04);
        settle();
        n_checks++; if (q_at(wr_addr, 0) !== 32'h0) begin n_fail++; $display("FAIL rd_wr_addr: got %h expected 00000000", q_at(wr_addr, 0)); end
        n_checks++; if (q_at(wr_data, 0) !== 32'h04030201) begin n_fail++; $display("FAIL rd_wr_data: got %h expected 04030201", q_at(wr_data, 0)); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rd_done: got %b expected 1", done); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_words();
        test_bad_checksum();
        test_len_bounds();
        test_start_abort();
        test_reset_in_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
